// File: rtl/iso16_trace_recorder.sv
// Passive trace recorder for the ISO-16 True Delivery Loop: timestamps state changes and
// seal-strobe rising edges into a circular buffer drained through a valid/ready port.
module iso16_trace_recorder #(
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DROP_WIDTH = 16,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned LvlW      = $clog2(DEPTH) + 1,
  localparam int unsigned EntW      = TS_WIDTH + 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic                  cfg_wrap_i,
  input  logic [2:0]            state_i,
  input  logic                  symmetry_ok_i,
  input  logic                  error_ok_i,
  input  logic                  true_delivery_i,
  input  logic                  seal_start_i,
  input  logic                  seal_ready_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [EntW-1:0]       rd_data_o,
  output logic [LvlW-1:0]       level_o,
  output logic                  full_o,
  output logic [DROP_WIDTH-1:0] drop_count_o
);

  logic [TS_WIDTH-1:0]   ts_q;
  logic [2:0]            prev_state_q;
  logic                  prev_start_q, prev_ready_q;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [EntW-1:0]       mem_q [DEPTH];

  logic [2:0]    evt;
  logic          push, pop, full, wr_en, rd_adv;
  logic [EntW-1:0] entry;

  assign full       = (level_q == LvlW'(DEPTH));
  assign rd_valid_o = (level_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o    = level_q;
  assign full_o     = full;
  assign drop_count_o = drop_q;

  always_comb begin
    evt   = {seal_ready_i & ~prev_ready_q, seal_start_i & ~prev_start_q,
             state_i != prev_state_q};
    push  = arm_i & (evt != 3'b000);
    pop   = rd_valid_o & rd_ready_i;
    entry = {ts_q, evt, state_i, symmetry_ok_i, error_ok_i, true_delivery_i};

    // A full buffer still accepts a write when the head leaves this cycle or wrap is on.
    wr_en  = push & (~full | pop | cfg_wrap_i);
    rd_adv = pop | (push & full & cfg_wrap_i);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;

    if (wr_en)  wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_adv) rd_ptr_d = rd_ptr_q + PtrW'(1);

    if (wr_en && !rd_adv) begin
      level_d = level_q + LvlW'(1);
    end else if (!wr_en && rd_adv) begin
      level_d = level_q - LvlW'(1);
    end

    if (push && full && !pop && (drop_q != '1)) drop_d = drop_q + DROP_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q         <= '0;
      prev_state_q <= 3'b000;
      prev_start_q <= 1'b0;
      prev_ready_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
    end else begin
      ts_q         <= ts_q + TS_WIDTH'(1);
      prev_state_q <= state_i;
      prev_start_q <= seal_start_i;
      prev_ready_q <= seal_ready_i;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
    end
  end

  // Storage has no reset; only entries covered by level are ever exposed.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem_q[wr_ptr_q] <= entry;
  end

endmodule
